ttt_neuron_bank: RTL and testbench

Parametrised bank of NUM_NEURONS token-counting neurons for the tick-tock-tokens core. It generalises the single-neuron tt_um_jleugeri_ticktocktokens datapath to N channels, configurable counter width and a selectable post-fire reset mode.
- Tick phase: input token events increment or decrement per-neuron signed counters.
- Tock phase: a strobe triggers a sequential scan that emits one spike event per neuron whose count reaches its threshold.
- Sits between the tinytapeout I/O wrapper (event decode) and the spike output serialiser.

---
 rtl/ttt_neuron_bank_if.sv | 13 +
 rtl/ttt_neuron_bank.sv | 162 ++++++++++++++++
 tb/tb_ttt_neuron_bank.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_neuron_bank_if.sv
// ttt_neuron_bank_if: valid/ready event channel carrying a neuron index and a
// token sign. Used for both the token input and the spike output of the bank.
interface ttt_neuron_bank_if #(
    parameter int ID_W = 2
) ();
    logic            valid;
    logic            ready;
    logic [ID_W-1:0] id;
    logic            neg;

    modport master (output valid, output id, output neg, input ready);
    modport slave  (input valid, input id, input neg, output ready);
endinterface

// File: rtl/ttt_neuron_bank.sv
// ttt_neuron_bank: bank of token-counting neurons. Between tocks, +/-1 token
// events move per-neuron saturating signed counters. A tock starts a scan that
// evaluates one neuron per cycle and emits a spike for each neuron whose count
// has reached its (non-zero) threshold, then resets or reduces that counter.
module ttt_neuron_bank #(
    parameter int NUM_NEURONS    = 4,
    parameter int COUNT_W        = 8,
    parameter int ID_W           = $clog2(NUM_NEURONS),
    parameter int RESET_MODE     = 0,
    parameter int DEFAULT_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst,
    ttt_neuron_bank_if.slave   i_evt,
    ttt_neuron_bank_if.master  o_spk,
    input  logic               i_tock,
    input  logic               i_cfg_we,
    input  logic [ID_W-1:0]    i_cfg_id,
    input  logic [COUNT_W-2:0] i_cfg_thresh,
    output logic               o_scan_done,
    output logic               o_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

    localparam logic [ID_W:0]             NUM_EXT  = (ID_W + 1)'(NUM_NEURONS);
    localparam logic [ID_W-1:0]           LAST_IDX = ID_W'(NUM_NEURONS - 1);
    localparam logic signed [COUNT_W-1:0] CNT_MAX  = {1'b0, {(COUNT_W - 1){1'b1}}};
    localparam logic signed [COUNT_W-1:0] CNT_MIN  = {1'b1, {(COUNT_W - 1){1'b0}}};
    localparam logic [COUNT_W-2:0]        THR_RST  = (COUNT_W - 1)'(DEFAULT_THRESH);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ID_W-1:0]            r_idx;
    logic [ID_W-1:0]            w_idx_nxt;
    logic                       r_scan_done;
    logic                       w_scan_done_nxt;
    logic                       r_overrun;
    logic signed [COUNT_W-1:0]  r_count  [NUM_NEURONS];
    logic [COUNT_W-2:0]         r_thresh [NUM_NEURONS];

    logic                       w_evt_hit;
    logic                       w_cfg_hit;
    logic                       w_handshake;
    logic                       w_last;
    logic                       w_fire;
    logic signed [COUNT_W-1:0]  w_thr_ext;

    // Out-of-range ids are accepted (ready stays high) but never touch state.
    assign w_evt_hit   = i_evt.valid && (r_state == S_IDLE) && ({1'b0, i_evt.id} < NUM_EXT);
    assign w_cfg_hit   = i_cfg_we && ({1'b0, i_cfg_id} < NUM_EXT);
    assign w_handshake = (r_state == S_EMIT) && o_spk.ready;
    assign w_last      = (r_idx == LAST_IDX);

    // Threshold is unsigned; zero-extend so the compare against the count is signed.
    assign w_thr_ext   = {1'b0, r_thresh[r_idx]};
    assign w_fire      = (r_thresh[r_idx] != '0) && (r_count[r_idx] >= w_thr_ext);

    assign i_evt.ready = (r_state == S_IDLE);
    assign o_spk.valid = (r_state == S_EMIT);
    assign o_spk.id    = r_idx;
    assign o_spk.neg   = 1'b0;
    assign o_scan_done = r_scan_done;
    assign o_overrun   = r_overrun;

    // Next-state and scan-index selection for the IDLE/SCAN/EMIT sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_scan_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_tock) begin
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (w_fire) begin
                    w_state_nxt = S_EMIT;
                end else if (w_last) begin
                    w_state_nxt     = S_IDLE;
                    w_idx_nxt       = '0;
                    w_scan_done_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_EMIT: begin
                if (o_spk.ready) begin
                    if (w_last) begin
                        w_state_nxt     = S_IDLE;
                        w_idx_nxt       = '0;
                        w_scan_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, scan index and the one-cycle scan_done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_scan_done <= w_scan_done_nxt;
        end
    end

    // Sticky overrun: a tock that arrives while a scan is still running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (i_tock && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    // Per-neuron counters and thresholds: token updates, post-fire reset, config writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are flops, not RAM, and must come out of reset defined, so every entry is reset.
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_count[i]  <= '0;
                r_thresh[i] <= THR_RST;
            end
        end else begin
            if (w_evt_hit) begin
                if (!i_evt.neg && (r_count[i_evt.id] != CNT_MAX)) begin
                    r_count[i_evt.id] <= r_count[i_evt.id] + COUNT_W'(1);
                end else if (i_evt.neg && (r_count[i_evt.id] != CNT_MIN)) begin
                    r_count[i_evt.id] <= r_count[i_evt.id] - COUNT_W'(1);
                end
            end
            // Firing implies count >= threshold > 0, so the subtraction cannot underflow.
            if (w_handshake) begin
                if (RESET_MODE == 0) begin
                    r_count[r_idx] <= '0;
                end else begin
                    r_count[r_idx] <= r_count[r_idx] - w_thr_ext;
                end
            end
            if (w_cfg_hit) begin
                r_thresh[i_cfg_id] <= i_cfg_thresh;
            end
        end
    end

endmodule

// File: tb/tb_ttt_neuron_bank.sv
// tb_ttt_neuron_bank: three bank instances (N=4 clear-on-fire, N=4
// subtract-on-fire, N=6 narrow counters) compared every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_ttt_neuron_bank;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared stimulus for u0/u1 and separate stimulus for u2.
    logic       t_rst, t_valid, t_neg, t_tock, t_we, t_ordy;
    logic [1:0] t_id, t_cid;
    logic [6:0] t_cth;
    logic       v2, neg2, tock2, we2, ordy2;
    logic [2:0] id2, cid2;
    logic [3:0] cth2;
    logic       done0, done1, done2, ovr0, ovr1, ovr2;

    ttt_neuron_bank_if #(.ID_W(2)) evt0 ();
    ttt_neuron_bank_if #(.ID_W(2)) spk0 ();
    ttt_neuron_bank_if #(.ID_W(2)) evt1 ();
    ttt_neuron_bank_if #(.ID_W(2)) spk1 ();
    ttt_neuron_bank_if #(.ID_W(3)) evt2 ();
    ttt_neuron_bank_if #(.ID_W(3)) spk2 ();

    assign evt0.valid = t_valid;  assign evt0.id = t_id;  assign evt0.neg = t_neg;
    assign evt1.valid = t_valid;  assign evt1.id = t_id;  assign evt1.neg = t_neg;
    assign evt2.valid = v2;       assign evt2.id = id2;   assign evt2.neg = neg2;
    assign spk0.ready = t_ordy;
    assign spk1.ready = t_ordy;
    assign spk2.ready = ordy2;

    ttt_neuron_bank #(.NUM_NEURONS(4), .COUNT_W(8), .RESET_MODE(0), .DEFAULT_THRESH(4)) u0 (
        .clk(clk), .rst(t_rst), .i_evt(evt0), .o_spk(spk0), .i_tock(t_tock),
        .i_cfg_we(t_we), .i_cfg_id(t_cid), .i_cfg_thresh(t_cth),
        .o_scan_done(done0), .o_overrun(ovr0));

    ttt_neuron_bank #(.NUM_NEURONS(4), .COUNT_W(8), .RESET_MODE(1), .DEFAULT_THRESH(4)) u1 (
        .clk(clk), .rst(t_rst), .i_evt(evt1), .o_spk(spk1), .i_tock(t_tock),
        .i_cfg_we(t_we), .i_cfg_id(t_cid), .i_cfg_thresh(t_cth),
        .o_scan_done(done1), .o_overrun(ovr1));

    ttt_neuron_bank #(.NUM_NEURONS(6), .COUNT_W(5), .RESET_MODE(0), .DEFAULT_THRESH(3)) u2 (
        .clk(clk), .rst(t_rst), .i_evt(evt2), .o_spk(spk2), .i_tock(tock2),
        .i_cfg_we(we2), .i_cfg_id(cid2), .i_cfg_thresh(cth2),
        .o_scan_done(done2), .o_overrun(ovr2));

    int n_checks = 0;
    int n_bad    = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit rst, valid, neg, tock, we, ordy;
        int id, cid, cth;
    } stim_t;

    typedef struct {
        bit ready, valid, done, ovr, ordy;
        int id;
    } obs_t;

    int mnn [3] = '{4, 4, 6};
    int mcw [3] = '{8, 8, 5};
    int mrm [3] = '{0, 1, 0};
    int mdth[3] = '{4, 4, 3};

    int mcnt[3][8];
    int mth [3][8];
    bit m_busy[3], m_spk[3], m_done[3], m_ovr[3];
    int m_pos[3];

    int spk_cnt[3];
    int spk_ids[3][$];

    function automatic stim_t get_stim(input int m);
        stim_t s;
        s.rst = t_rst;
        if (m < 2) begin
            s.valid = t_valid; s.neg = t_neg; s.tock = t_tock; s.we = t_we; s.ordy = t_ordy;
            s.id = int'(t_id); s.cid = int'(t_cid); s.cth = int'(t_cth);
        end else begin
            s.valid = v2; s.neg = neg2; s.tock = tock2; s.we = we2; s.ordy = ordy2;
            s.id = int'(id2); s.cid = int'(cid2); s.cth = int'(cth2);
        end
        return s;
    endfunction

    function automatic obs_t get_obs(input int m);
        obs_t o;
        case (m)
            0: begin o.ready = evt0.ready; o.valid = spk0.valid; o.id = int'(spk0.id);
                     o.done = done0; o.ovr = ovr0; o.ordy = t_ordy; end
            1: begin o.ready = evt1.ready; o.valid = spk1.valid; o.id = int'(spk1.id);
                     o.done = done1; o.ovr = ovr1; o.ordy = t_ordy; end
            default: begin o.ready = evt2.ready; o.valid = spk2.valid; o.id = int'(spk2.id);
                     o.done = done2; o.ovr = ovr2; o.ordy = ordy2; end
        endcase
        return o;
    endfunction

    // A scan walks neuron positions 0..N-1; each position either produces one
    // spike (held until accepted) or is skipped; the walk ends with a done pulse.
    task automatic model_step(input int m);
        stim_t s;
        int    n, mx, mn;
        bit    done_n;
        s  = get_stim(m);
        n  = mnn[m];
        mx = (1 << (mcw[m] - 1)) - 1;
        mn = -(1 << (mcw[m] - 1));
        if (s.rst) begin
            for (int i = 0; i < 8; i++) begin
                mcnt[m][i] = 0;
                mth[m][i]  = mdth[m];
            end
            m_busy[m] = 0; m_spk[m] = 0; m_done[m] = 0; m_ovr[m] = 0; m_pos[m] = 0;
            return;
        end
        done_n = 0;
        if (!m_busy[m]) begin
            if (s.valid && s.id < n) begin
                if (!s.neg && mcnt[m][s.id] < mx) mcnt[m][s.id]++;
                if (s.neg && mcnt[m][s.id] > mn)  mcnt[m][s.id]--;
            end
            if (s.tock) begin
                m_busy[m] = 1;
                m_pos[m]  = 0;
            end
        end else begin
            bit advance;
            advance = 0;
            if (s.tock) m_ovr[m] = 1;
            if (!m_spk[m]) begin
                if (mth[m][m_pos[m]] != 0 && mcnt[m][m_pos[m]] >= mth[m][m_pos[m]]) m_spk[m] = 1;
                else advance = 1;
            end else if (s.ordy) begin
                if (mrm[m] == 0) mcnt[m][m_pos[m]] = 0;
                else             mcnt[m][m_pos[m]] -= mth[m][m_pos[m]];
                m_spk[m] = 0;
                advance  = 1;
            end
            if (advance) begin
                if (m_pos[m] == n - 1) begin
                    m_busy[m] = 0;
                    m_pos[m]  = 0;
                    done_n    = 1;
                end else begin
                    m_pos[m]++;
                end
            end
        end
        if (s.we && s.cid < n) mth[m][s.cid] = s.cth;
        m_done[m] = done_n;
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) model_step(m);
    end

    // Compare process: every cycle, all observable outputs and per-neuron state.
    always @(negedge clk) begin : cmp_blk
        obs_t o;
        if (cmp_en) begin
            for (int m = 0; m < 3; m++) begin
                o = get_obs(m);
                check($sformatf("u%0d_in_ready", m), int'(o.ready), int'(!m_busy[m]));
                check($sformatf("u%0d_out_valid", m), int'(o.valid), int'(m_spk[m]));
                if (m_spk[m]) check($sformatf("u%0d_out_id", m), o.id, m_pos[m]);
                check($sformatf("u%0d_scan_done", m), int'(o.done), int'(m_done[m]));
                check($sformatf("u%0d_overrun", m), int'(o.ovr), int'(m_ovr[m]));
                if (o.valid && o.ordy) begin
                    spk_cnt[m]++;
                    spk_ids[m].push_back(o.id);
                end
            end
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u0_cnt%0d", i), int'(u0.r_count[i]), mcnt[0][i]);
                check($sformatf("u1_cnt%0d", i), int'(u1.r_count[i]), mcnt[1][i]);
                check($sformatf("u0_thr%0d", i), int'(u0.r_thresh[i]), mth[0][i]);
                check($sformatf("u1_thr%0d", i), int'(u1.r_thresh[i]), mth[1][i]);
            end
            for (int i = 0; i < 6; i++) begin
                check($sformatf("u2_cnt%0d", i), int'(u2.r_count[i]), mcnt[2][i]);
                check($sformatf("u2_thr%0d", i), int'(u2.r_thresh[i]), mth[2][i]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        t_rst = 1'b1;
        cyc();
        t_rst = 1'b0;
    endtask

    task automatic clear_spikes();
        for (int m = 0; m < 3; m++) begin
            spk_cnt[m] = 0;
            spk_ids[m].delete();
        end
    endtask

    task automatic send(input int id, input bit neg, input int count);
        for (int i = 0; i < count; i++) begin
            t_valid = 1'b1;
            t_id    = 2'(id);
            t_neg   = neg;
            cyc();
        end
        t_valid = 1'b0;
    endtask

    task automatic set_thr(input int id, input int thr);
        t_we  = 1'b1;
        t_cid = 2'(id);
        t_cth = 7'(thr);
        cyc();
        t_we  = 1'b0;
    endtask

    // Waits (bounded) until both u0 and u1 have pulsed scan_done; lat0 is the
    // number of edges until u0's pulse becomes visible.
    task automatic wait_done(output int lat0);
        bit d0, d1;
        d0 = 0; d1 = 0; lat0 = -1;
        for (int k = 1; k <= 60 && !(d0 && d1); k++) begin
            cyc();
            if (done0 && !d0) begin d0 = 1; lat0 = k; end
            if (done1) d1 = 1;
        end
        check("scan_complete", int'(d0 && d1), 1);
    endtask

    task automatic run_scan(output int lat0);
        clear_spikes();
        t_tock = 1'b1;
        cyc();
        t_tock  = 1'b0;
        t_valid = 1'b0;
        wait_done(lat0);
    endtask

    task automatic wait_valid0();
        for (int k = 0; k < 10 && !spk0.valid; k++) cyc();
        check("out_valid_seen", int'(spk0.valid), 1);
    endtask

    initial begin
        int lat;
        t_rst = 1'b1; t_valid = 0; t_neg = 0; t_tock = 0; t_we = 0; t_ordy = 1;
        t_id = 0; t_cid = 0; t_cth = 0;
        v2 = 0; neg2 = 0; tock2 = 0; we2 = 0; ordy2 = 1; id2 = 0; cid2 = 0; cth2 = 0;
        cyc();
        cyc();
        t_rst  = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        check("rst_in_ready", int'(evt0.ready), 1);
        check("rst_out_valid", int'(spk0.valid), 0);
        check("rst_out_id", int'(spk0.id), 0);
        check("rst_scan_done", int'(done0), 0);
        check("rst_overrun", int'(ovr1), 0);

        // 1: four tokens to neuron 2, one spike, 5 cycles tock -> scan_done.
        send(2, 0, 4);
        run_scan(lat);
        check("t1_latency", lat, 5);
        check("t1_spikes_u0", spk_cnt[0], 1);
        check("t1_id_u0", spk_ids[0].size() > 0 ? spk_ids[0][0] : -1, 2);
        check("t1_cnt2_u0", int'(u0.r_count[2]), 0);
        check("t1_cnt2_u1", int'(u1.r_count[2]), 0);

        // 2: threshold 3, seven tokens, three scans.
        do_reset();
        set_thr(1, 3);
        send(1, 0, 7);
        run_scan(lat);
        check("t2_s1_spikes_u1", spk_cnt[1], 1);
        check("t2_s1_id_u1", spk_ids[1].size() > 0 ? spk_ids[1][0] : -1, 1);
        check("t2_s1_spikes_u0", spk_cnt[0], 1);
        run_scan(lat);
        check("t2_s2_spikes_u1", spk_cnt[1], 1);
        check("t2_s2_spikes_u0", spk_cnt[0], 0);
        check("t2_cnt1_u1", int'(u1.r_count[1]), 1);
        run_scan(lat);
        check("t2_s3_spikes_u1", spk_cnt[1], 0);

        // 3: saturation at both ends, no wrap.
        do_reset();
        send(0, 0, 200);
        check("t3_cnt0_max", int'(u0.r_count[0]), 127);
        send(3, 1, 300);
        check("t3_cnt3_min", int'(u1.r_count[3]), -128);
        run_scan(lat);
        check("t3_spikes_u0", spk_cnt[0], 1);
        check("t3_id_u0", spk_ids[0].size() > 0 ? spk_ids[0][0] : -1, 0);
        check("t3_cnt0_u1", int'(u1.r_count[0]), 123);
        send(3, 0, 131);
        check("t3_cnt3_recover", int'(u0.r_count[3]), 3);

        // 4: back-pressure, stable out_id, mid-scan tock sets overrun.
        do_reset();
        send(0, 0, 5);
        send(3, 0, 5);
        clear_spikes();
        t_ordy = 1'b0;
        t_tock = 1'b1;
        cyc();
        t_tock = 1'b0;
        wait_valid0();
        for (int j = 0; j < 5; j++) begin
            check("t4_hold_valid", int'(spk0.valid), 1);
            check("t4_hold_id", int'(spk0.id), 0);
            check("t4_hold_ready", int'(evt1.ready), 0);
            if (j == 2) t_tock = 1'b1;
            cyc();
            t_tock = 1'b0;
        end
        t_ordy = 1'b1;
        wait_done(lat);
        check("t4_spikes_u0", spk_cnt[0], 2);
        check("t4_order_u0", spk_ids[0].size() == 2 ? spk_ids[0][0] * 10 + spk_ids[0][1] : -1, 3);
        check("t4_spikes_u1", spk_cnt[1], 2);
        check("t4_overrun_u0", int'(ovr0), 1);
        check("t4_overrun_u1", int'(ovr1), 1);

        // 5: disabled neuron; event in the tock cycle is included in the scan.
        do_reset();
        set_thr(2, 0);
        send(2, 0, 10);
        send(1, 0, 3);
        t_valid = 1'b1; t_id = 2'd1; t_neg = 1'b0;
        run_scan(lat);
        check("t5_spikes_u0", spk_cnt[0], 1);
        check("t5_id_u0", spk_ids[0].size() > 0 ? spk_ids[0][0] : -1, 1);
        check("t5_cnt2_u1", int'(u1.r_count[2]), 10);

        // 6: reset while a spike is held.
        do_reset();
        send(0, 0, 4);
        t_ordy = 1'b0;
        t_tock = 1'b1;
        cyc();
        t_tock = 1'b0;
        wait_valid0();
        t_tock = 1'b1;
        cyc();
        t_tock = 1'b0;
        check("t6_overrun_set", int'(ovr0), 1);
        clear_spikes();
        do_reset();
        check("t6_out_valid", int'(spk0.valid), 0);
        check("t6_overrun", int'(ovr0), 0);
        check("t6_in_ready", int'(evt0.ready), 1);
        check("t6_cnt0", int'(u0.r_count[0]), 0);
        for (int i = 0; i < 4; i++) check($sformatf("t6_thr%0d", i), int'(u1.r_thresh[i]), 4);
        t_ordy = 1'b1;
        for (int j = 0; j < 6; j++) cyc();
        check("t6_no_spikes", spk_cnt[0], 0);

        // Randomised traffic on all three instances, with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            t_rst   = ($urandom_range(0, 599) == 0);
            t_valid = ($urandom_range(0, 99) < 60);
            t_id    = 2'($urandom_range(0, 3));
            t_neg   = ($urandom_range(0, 99) < 35);
            t_tock  = ($urandom_range(0, 99) < 6);
            t_we    = ($urandom_range(0, 99) < 4);
            t_cid   = 2'($urandom_range(0, 3));
            t_cth   = 7'($urandom_range(0, 9));
            t_ordy  = ($urandom_range(0, 99) < 70);
            v2      = ($urandom_range(0, 99) < 60);
            id2     = 3'($urandom_range(0, 7));
            neg2    = ($urandom_range(0, 99) < 30);
            tock2   = ($urandom_range(0, 99) < 6);
            we2     = ($urandom_range(0, 99) < 5);
            cid2    = 3'($urandom_range(0, 7));
            cth2    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
            ordy2   = ($urandom_range(0, 99) < 70);
            cyc();
        end
        t_rst = 0; t_valid = 0; t_tock = 0; t_we = 0; t_ordy = 1;
        v2 = 0; tock2 = 0; we2 = 0; ordy2 = 1;
        for (int j = 0; j < 20; j++) cyc();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
